module_arbitro_de_bus: RTL and testbench

- Two-master round-robin arbiter and access sequencer in front of module_conductor_de_bus.
- Shares the single 32-bit peripheral/memory bus between the CPU data port (master 0) and the UART/SPI block-transfer engine (master 1).
- Latches the winning request, drives address/data/write-enable to the bus conductor, and inserts region-dependent wait states.
- Returns read data and a one-cycle acknowledge to the granted master.

---
 rtl/pkg_arbitro_bus.sv | 36 +++
 rtl/module_decodificador_espera.sv | 38 +++
 rtl/module_arbitro_de_bus.sv | 132 +++++++++++++
 tb/tb_module_arbitro_de_bus.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_arbitro_bus.sv
// Shared types and address map for the two-master bus arbiter and its wait-state decoder.
package pkg_arbitro_bus;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        REG_RAM      = 3'd0,
        REG_IO       = 3'd1,
        REG_SPI      = 3'd2,
        REG_ROM      = 3'd3,
        REG_UNMAPPED = 3'd4
    } region_t;

    localparam logic [31:0] RAM_BASE   = 32'h0000_1000;
    localparam logic [31:0] RAM_LIMIT  = 32'h0000_13FF;
    localparam logic [31:0] IO_BASE    = 32'h0000_2000;
    localparam logic [31:0] IO_LIMIT   = 32'h0000_20FF;
    localparam logic [31:0] SPI_BASE   = 32'h0000_2100;
    localparam logic [31:0] SPI_LIMIT  = 32'h0000_2FFF;
    localparam logic [31:0] HOLE_BASE  = 32'h0000_1400;
    localparam logic [31:0] HOLE_LIMIT = 32'h0000_1FFF;

    // Inclusive bounds; anything not listed (low ROM and 0x3000 upward) is ROM.
    function automatic region_t region_of(input logic [31:0] a);
        if (a >= RAM_BASE && a <= RAM_LIMIT)        return REG_RAM;
        else if (a >= HOLE_BASE && a <= HOLE_LIMIT) return REG_UNMAPPED;
        else if (a >= IO_BASE && a <= IO_LIMIT)     return REG_IO;
        else if (a >= SPI_BASE && a <= SPI_LIMIT)   return REG_SPI;
        else                                        return REG_ROM;
    endfunction

endpackage

// File: rtl/module_decodificador_espera.sv
// Combinational address -> wait-count / unmapped-flag decoder, shared with the ROM loader.
// With ARB_DECODE_ERR_EN the 0x1400-0x1FFF hole is flagged unmapped; otherwise it decodes as ROM.
module module_decodificador_espera
    import pkg_arbitro_bus::*;
#(
    parameter int unsigned WAIT_RAM = 0,
    parameter int unsigned WAIT_IO  = 1,
    parameter int unsigned WAIT_SPI = 2,
    parameter int unsigned WAIT_ROM = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic [31:0]      addr,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             unmapped
);

    region_t region;

    always_comb begin
        region = region_of(addr);
`ifndef ARB_DECODE_ERR_EN
        if (region == REG_UNMAPPED) region = REG_ROM;
`endif
        wait_cnt = CNT_W'(WAIT_ROM);
        unmapped = 1'b0;
        case (region)
            REG_RAM:      wait_cnt = CNT_W'(WAIT_RAM);
            REG_IO:       wait_cnt = CNT_W'(WAIT_IO);
            REG_SPI:      wait_cnt = CNT_W'(WAIT_SPI);
            REG_UNMAPPED: begin
                wait_cnt = '0;
                unmapped = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/module_arbitro_de_bus.sv
// Two-master round-robin bus arbiter: grant -> WAIT+1 ACCESS cycles -> one-cycle ack, then one IDLE cycle.
// Masters hold req until ack; decode errors (ARB_DECODE_ERR_EN) return err_o with ack and zero data.
module module_arbitro_de_bus
    import pkg_arbitro_bus::*;
#(
    parameter int unsigned WAIT_RAM = 0,
    parameter int unsigned WAIT_IO  = 1,
    parameter int unsigned WAIT_SPI = 2,
    parameter int unsigned WAIT_ROM = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_rdata_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic        err_o
);

    state_t            state, state_nx;
    logic              rr_m1;
    logic [CNT_W-1:0]  cnt;
    logic              unmapped_q;
    logic              pick_m1;
    logic [31:0]       win_addr;
    logic [CNT_W-1:0]  win_wait;
    logic              win_unmapped;
    logic [31:0]       rd_val;

    // m1 wins when it is alone, or when both request and the pointer favours it.
    always_comb begin
        pick_m1  = m1_req_i & (~m0_req_i | rr_m1);
        win_addr = pick_m1 ? m1_addr_i : m0_addr_i;
        rd_val   = unmapped_q ? 32'h0 : bus_rdata_i;
    end

    module_decodificador_espera #(
        .WAIT_RAM (WAIT_RAM),
        .WAIT_IO  (WAIT_IO),
        .WAIT_SPI (WAIT_SPI),
        .WAIT_ROM (WAIT_ROM),
        .CNT_W    (CNT_W)
    ) u_dec (
        .addr     (win_addr),
        .wait_cnt (win_wait),
        .unmapped (win_unmapped)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (m0_req_i | m1_req_i) state_nx = ACCESS;
            ACCESS:  if (cnt == '0)           state_nx = ACK;
            ACK:                              state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_m1       <= 1'b0;
            cnt         <= '0;
            unmapped_q  <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            grant_o     <= 2'b00;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            m0_ack_o    <= 1'b0;
            m1_ack_o    <= 1'b0;
            m0_rdata_o  <= 32'h0;
            m1_rdata_o  <= 32'h0;
        end else begin
            // Strobe and ack are single-cycle pulses.
            bus_we_o <= 1'b0;
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                IDLE: if (m0_req_i | m1_req_i) begin
                    bus_addr_o  <= win_addr;
                    bus_wdata_o <= pick_m1 ? m1_wdata_i : m0_wdata_i;
                    bus_we_o    <= (pick_m1 ? m1_we_i : m0_we_i) & ~win_unmapped;
                    grant_o     <= pick_m1 ? 2'b10 : 2'b01;
                    busy_o      <= 1'b1;
                    cnt         <= win_wait;
                    unmapped_q  <= win_unmapped;
                end
                ACCESS: if (cnt == '0) begin
                    err_o <= unmapped_q;
                    if (grant_o[1]) begin
                        m1_rdata_o <= rd_val;
                        m1_ack_o   <= 1'b1;
                    end else begin
                        m0_rdata_o <= rd_val;
                        m0_ack_o   <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                ACK: begin
                    rr_m1   <= grant_o[0];
                    grant_o <= 2'b00;
                    busy_o  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_arbitro_de_bus.sv
// Directed bench for module_arbitro_de_bus; decode-hole expectations follow ARB_DECODE_ERR_EN.
module tb_module_arbitro_de_bus;

    logic        clk, rst;
    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        bus_we, busy, err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  grant;
    int          checks, failures;

    module_arbitro_de_bus dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
        .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata), .grant_o(grant), .busy_o(busy), .err_o(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (grant !== 2'b00 || busy !== 1'b0 || bus_we !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got grant=%b busy=%b we=%b err=%b exp 00 0 0 0", grant, busy, bus_we, err); end
        checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_bus got addr=%h wdata=%h exp 0 0", bus_addr, bus_wdata); end
        checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_masters got ack=%b%b rd0=%h rd1=%h exp 0", m0_ack, m1_ack, m0_rdata, m1_rdata); end
        rst = 1'b0;
        tick();
        checks++; if (grant !== 2'b00) begin
            failures++; $display("FAIL idle_no_req got grant=%b exp 00", grant); end
    endtask

    task automatic test_read_ram();
        int we_seen;
        we_seen = 0;
        bus_rdata = 32'd14;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000;
        tick();
        if (bus_we) we_seen++;
        checks++; if (bus_addr !== 32'h1000 || grant !== 2'b01 || busy !== 1'b1) begin
            failures++; $display("FAIL read_c1 got addr=%h grant=%b busy=%b exp 1000 01 1", bus_addr, grant, busy); end
        tick();
        if (bus_we) we_seen++;
        checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'd14 || m1_ack !== 1'b0) begin
            failures++; $display("FAIL read_ack got ack0=%b rd=%0d ack1=%b exp 1 14 0", m0_ack, m0_rdata, m1_ack); end
        m0_req = 1'b0;
        tick();
        if (bus_we) we_seen++;
        checks++; if (m0_ack !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || m0_rdata !== 32'd14) begin
            failures++; $display("FAIL read_after got ack=%b grant=%b busy=%b rd=%0d exp 0 00 0 14", m0_ack, grant, busy, m0_rdata); end
        checks++; if (we_seen !== 0) begin
            failures++; $display("FAIL read_no_strobe got %0d strobes exp 0", we_seen); end
    endtask

    task automatic test_write_spi();
        int we_n, we_c, ack_c;
        logic grant_ok, m0_ack_seen;
        logic [31:0] wd, rd;
        we_n = 0; we_c = -1; ack_c = -1; grant_ok = 1'b1; m0_ack_seen = 1'b0; wd = 0; rd = 0;
        bus_rdata = 32'h33;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2100; m1_wdata = 32'hA5;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bus_we) begin we_n++; we_c = c; wd = bus_wdata; end
            if (m1_ack && ack_c < 0) begin ack_c = c; rd = m1_rdata; m1_req = 1'b0; m1_we = 1'b0; end
            if (c <= 4 && grant !== 2'b10) grant_ok = 1'b0;
            if (m0_ack) m0_ack_seen = 1'b1;
        end
        checks++; if (we_n !== 1 || we_c !== 1) begin
            failures++; $display("FAIL spi_strobe got count=%0d cycle=%0d exp 1 1", we_n, we_c); end
        checks++; if (wd !== 32'hA5) begin
            failures++; $display("FAIL spi_wdata got %h exp a5", wd); end
        checks++; if (ack_c !== 4) begin
            failures++; $display("FAIL spi_ack_cycle got %0d exp 4", ack_c); end
        checks++; if (grant_ok !== 1'b1 || m0_ack_seen !== 1'b0 || grant !== 2'b00) begin
            failures++; $display("FAIL spi_grant got ok=%b m0ack=%b end=%b exp 1 0 00", grant_ok, m0_ack_seen, grant); end
        checks++; if (rd !== 32'h33) begin
            failures++; $display("FAIL spi_rdata got %h exp 33", rd); end
    endtask

    task automatic test_back_to_back();
        int n;
        int ids [8];
        int cyc [8];
        logic both;
        n = 0; both = 1'b0;
        bus_rdata = 32'h5A;
        m0_we = 1'b0; m0_addr = 32'h2008; m1_we = 1'b0; m1_addr = 32'h2020;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int c = 1; c <= 60 && n < 8; c++) begin
            tick();
            if (m0_ack && m1_ack) both = 1'b1;
            else if (m0_ack || m1_ack) begin
                ids[n] = m1_ack ? 1 : 0;
                cyc[n] = c;
                n++;
                if (n == 8) begin m0_req = 1'b0; m1_req = 1'b0; end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        checks++; if (n !== 8 || both !== 1'b0) begin
            failures++; $display("FAIL b2b_count got acks=%0d both=%b exp 8 0", n, both); end
        for (int i = 0; i < n; i++) begin
            checks++; if (ids[i] !== i % 2) begin
                failures++; $display("FAIL b2b_order[%0d] got m%0d exp m%0d", i, ids[i], i % 2); end
            checks++; if (cyc[i] !== 3 + 4 * i) begin
                failures++; $display("FAIL b2b_cycle[%0d] got %0d exp %0d", i, cyc[i], 3 + 4 * i); end
        end
    endtask

    task automatic test_addr_hold();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200C;
        tick();
        checks++; if (bus_addr !== 32'h200C) begin
            failures++; $display("FAIL hold_c1 got %h exp 200c", bus_addr); end
        m0_addr = 32'h2010;
        tick();
        checks++; if (bus_addr !== 32'h200C || m0_ack !== 1'b0) begin
            failures++; $display("FAIL hold_c2 got addr=%h ack=%b exp 200c 0", bus_addr, m0_ack); end
        tick();
        checks++; if (bus_addr !== 32'h200C || m0_ack !== 1'b1) begin
            failures++; $display("FAIL hold_ack got addr=%h ack=%b exp 200c 1", bus_addr, m0_ack); end
        m0_req = 1'b0;
        tick();
        checks++; if (bus_addr !== 32'h200C || grant !== 2'b00) begin
            failures++; $display("FAIL hold_retain got addr=%h grant=%b exp 200c 00", bus_addr, grant); end
    endtask

    task automatic test_reset_mid();
        logic stray;
        int ack_c;
        stray = 1'b0; ack_c = -1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h2004; m0_wdata = 32'h55;
        tick();
        checks++; if (bus_we !== 1'b1 || grant !== 2'b01) begin
            failures++; $display("FAIL rstmid_pre got we=%b grant=%b exp 1 01", bus_we, grant); end
        rst = 1'b1;
        #1;
        checks++; if (bus_we !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || m0_ack !== 1'b0) begin
            failures++; $display("FAIL rstmid_clear got we=%b grant=%b busy=%b addr=%h wd=%h ack=%b exp all 0",
                                 bus_we, grant, busy, bus_addr, bus_wdata, m0_ack); end
        m0_req = 1'b0; m0_we = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (m0_ack || m1_ack || bus_we || grant !== 2'b00) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_ack got activity=%b exp 0", stray); end
        m0_addr = 32'h2008; m1_addr = 32'h2020; m1_we = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        checks++; if (grant !== 2'b01) begin
            failures++; $display("FAIL rstmid_rr got grant=%b exp 01", grant); end
        for (int c = 2; c <= 6 && ack_c < 0; c++) begin
            tick();
            if (m0_ack) begin ack_c = c; m0_req = 1'b0; m1_req = 1'b0; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        checks++; if (ack_c !== 3) begin
            failures++; $display("FAIL rstmid_ack got %0d exp 3", ack_c); end
    endtask

    task automatic test_decode_range();
        int we_n, ack_c;
        logic err_at_ack;
        logic [31:0] rd;
        int exp_ack, exp_we;
        logic exp_err;
        logic [31:0] exp_rd;
`ifdef ARB_DECODE_ERR_EN
        exp_ack = 2; exp_we = 0; exp_err = 1'b1; exp_rd = 32'h0;
`else
        exp_ack = 3; exp_we = 1; exp_err = 1'b0; exp_rd = 32'h77;
`endif
        we_n = 0; ack_c = -1; err_at_ack = 1'bx; rd = 32'hx;
        bus_rdata = 32'h77;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1800; m0_wdata = 32'h99;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bus_we) we_n++;
            if (m0_ack && ack_c < 0) begin ack_c = c; err_at_ack = err; rd = m0_rdata; m0_req = 1'b0; m0_we = 1'b0; end
        end
        checks++; if (ack_c !== exp_ack) begin
            failures++; $display("FAIL hole_ack got %0d exp %0d", ack_c, exp_ack); end
        checks++; if (we_n !== exp_we) begin
            failures++; $display("FAIL hole_strobe got %0d exp %0d", we_n, exp_we); end
        checks++; if (err_at_ack !== exp_err || rd !== exp_rd) begin
            failures++; $display("FAIL hole_err got err=%b rd=%h exp %b %h", err_at_ack, rd, exp_err, exp_rd); end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [8];
        int exp_c [8];
        int ack_c;
        addrs = '{32'h13FF, 32'h1400, 32'h1000, 32'h0FFF, 32'h20FF, 32'h2100, 32'h2FFF, 32'h3000};
`ifdef ARB_DECODE_ERR_EN
        exp_c = '{2, 2, 2, 3, 3, 4, 4, 3};
`else
        exp_c = '{2, 3, 2, 3, 3, 4, 4, 3};
`endif
        m0_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ack_c = -1;
            m0_addr = addrs[i];
            m0_req = 1'b1;
            for (int c = 1; c <= 7; c++) begin
                tick();
                if (m0_ack && ack_c < 0) begin ack_c = c; m0_req = 1'b0; end
            end
            m0_req = 1'b0;
            checks++; if (ack_c !== exp_c[i]) begin
                failures++; $display("FAIL bound_%h got ack cycle %0d exp %0d", addrs[i], ack_c, exp_c[i]); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        bus_rdata = 32'h0;
        test_reset();
        test_read_ram();
        test_write_spi();
        test_back_to_back();
        test_addr_hold();
        test_reset_mid();
        test_decode_range();
        test_boundaries();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
